// File: rtl/reorder_collector.sv
// Reorders results from n_inputs variable-latency units back into round-robin issue order.
// Latency: 1 cycle from capture of the head slot to out_vld; every output is registered.
// Backpressure: none; one word drains per cycle whenever the head slot holds data.
module reorder_collector #(
    parameter int width     = 16,
    parameter int n_inputs  = 5,
    parameter int idx_width = $clog2(n_inputs),
    parameter int cnt_width = $clog2(n_inputs + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [n_inputs-1:0]         up_vld,
    input  logic [n_inputs*width-1:0]   up_data,
    output logic                        out_vld,
    output logic [width-1:0]            out_data,
    output logic [idx_width-1:0]        out_idx,
    output logic [cnt_width-1:0]        fill,
    output logic                        overflow
);

    logic [n_inputs-1:0]  slot_vld;
    logic [width-1:0]     slot_dat [n_inputs];
    logic [idx_width-1:0] rd_ptr;

    logic                 drain;
    logic [n_inputs-1:0]  drain_mask;
    logic [n_inputs-1:0]  cap_mask;
    logic [n_inputs-1:0]  ovf_mask;
    logic [cnt_width-1:0] cap_cnt;
    logic [cnt_width-1:0] fill_nxt;
    logic [idx_width-1:0] rd_ptr_nxt;

    // Drain decision uses the registered flags, so a same-edge return to the head slot
    // is stored behind the word being emitted rather than bypassing it.
    always_comb begin
        drain      = slot_vld[rd_ptr];
        drain_mask = '0;
        if (drain) begin
            drain_mask[rd_ptr] = 1'b1;
        end
        cap_mask = up_vld & (~slot_vld | drain_mask);
        ovf_mask = up_vld & slot_vld & ~drain_mask;
        cap_cnt  = '0;
        for (int i = 0; i < n_inputs; i++) begin
            cap_cnt = cap_cnt + cnt_width'(cap_mask[i]);
        end
        fill_nxt   = fill + cap_cnt - cnt_width'(drain);
        rd_ptr_nxt = (rd_ptr == idx_width'(n_inputs - 1)) ? '0 : rd_ptr + idx_width'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < n_inputs; i++) begin
                slot_dat[i] <= '0;
            end
        end else begin
            for (int i = 0; i < n_inputs; i++) begin
                if (up_vld[i]) begin
                    slot_dat[i] <= up_data[i*width +: width];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_vld <= '0;
            rd_ptr   <= '0;
            out_vld  <= 1'b0;
            out_data <= '0;
            out_idx  <= '0;
            fill     <= '0;
            overflow <= 1'b0;
        end else begin
            slot_vld <= (slot_vld & ~drain_mask) | up_vld;
            out_vld  <= drain;
            if (drain) begin
                out_data <= slot_dat[rd_ptr];
                out_idx  <= rd_ptr;
                rd_ptr   <= rd_ptr_nxt;
            end
            fill <= fill_nxt;
            if (|ovf_mask) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_reorder_collector.sv
// Directed and randomized bench for reorder_collector against a slot-array reference model.
module tb_reorder_collector;

    localparam int W = 16;
    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic [N-1:0]   up_vld = '0;
    logic [N*W-1:0] up_data = '0;
    logic           out_vld;
    logic [W-1:0]   out_data;
    logic [2:0]     out_idx;
    logic [2:0]     fill;
    logic           overflow;

    reorder_collector #(.width(W), .n_inputs(N)) dut (
        .clk(clk), .rst(rst), .up_vld(up_vld), .up_data(up_data),
        .out_vld(out_vld), .out_data(out_data), .out_idx(out_idx),
        .fill(fill), .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Reference model: what each slot holds, where the reader is, what was last emitted.
    logic         m_vld [N];
    logic [W-1:0] m_dat [N];
    int           m_rd;
    logic         e_vld;
    logic [W-1:0] e_dat;
    int           e_idx;
    logic         e_ovf;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int model_fill();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_vld[i] ? 1 : 0;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_vld[i] = 1'b0;
            m_dat[i] = '0;
        end
        m_rd = 0; e_vld = 1'b0; e_dat = '0; e_idx = 0; e_ovf = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] v, input logic [N*W-1:0] d);
        int  head = m_rd;
        bit  dr   = m_vld[head];
        for (int i = 0; i < N; i++)
            if (v[i] && m_vld[i] && !(dr && i == head)) e_ovf = 1'b1;
        e_vld = dr;
        if (dr) begin
            e_dat = m_dat[head];
            e_idx = head;
            m_vld[head] = 1'b0;
            m_rd = (head + 1) % N;
        end
        for (int i = 0; i < N; i++)
            if (v[i]) begin
                m_vld[i] = 1'b1;
                m_dat[i] = d[i*W +: W];
            end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".out_vld"},  32'(out_vld),  32'(e_vld));
        check({tag, ".out_data"}, 32'(out_data), 32'(e_dat));
        check({tag, ".out_idx"},  32'(out_idx),  32'(e_idx));
        check({tag, ".fill"},     32'(fill),     32'(model_fill()));
        check({tag, ".overflow"}, 32'(overflow), 32'(e_ovf));
    endtask

    // Drive one cycle of returns, clock it into both DUT and model, compare #1 after the edge.
    task automatic step(input string tag, input logic [N-1:0] v, input logic [N*W-1:0] d);
        up_vld  = v;
        up_data = d;
        @(posedge clk);
        model_edge(v, d);
        #1;
        up_vld  = '0;
        check_model(tag);
    endtask

    function automatic logic [N*W-1:0] lane(input int i, input logic [W-1:0] x);
        logic [N*W-1:0] r = '0;
        r[i*W +: W] = x;
        return r;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".out_vld"},  32'(out_vld),  32'd0);
        check({tag, ".out_data"}, 32'(out_data), 32'd0);
        check({tag, ".out_idx"},  32'(out_idx),  32'd0);
        check({tag, ".fill"},     32'(fill),     32'd0);
        check({tag, ".overflow"}, 32'(overflow), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        up_vld = '0;
        #1;
        model_reset();
        check_zero(tag);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [N*W-1:0] d;

        // Reset then idle.
        @(negedge clk);
        do_reset("rst");
        for (int k = 0; k < 3; k++) step("idle", '0, '0);
        check_zero("idle_end");

        // In-order returns: each word out one cycle after its capture.
        for (int i = 0; i < N; i++) step("inorder", N'(1) << i, lane(i, 16'h0A00 + 16'(i)));
        step("inorder_tail", '0, '0);
        check("inorder_last_data", 32'(out_data), 32'h0A04);
        check("inorder_last_idx",  32'(out_idx),  32'd4);
        step("inorder_idle", '0, '0);

        // Reverse returns: head-of-line blocking until slot 0 arrives.
        for (int u = N - 1; u >= 0; u--) begin
            step("reverse", N'(1) << u, lane(u, 16'h0B00 + 16'(u)));
            check("reverse_blocked", 32'(out_vld), 32'd0);
        end
        check("reverse_fill_peak", 32'(fill), 32'd5);
        for (int k = 0; k < N; k++) begin
            step("reverse_drain", '0, '0);
            check("reverse_idx", 32'(out_idx), 32'(k));
        end
        check("reverse_no_ovf", 32'(overflow), 32'd0);

        // All units in one cycle, twice, exercising pointer wrap.
        for (int r = 0; r < 2; r++) begin
            d = '0;
            for (int i = 0; i < N; i++) d |= lane(i, 16'hC000 + 16'(r*16 + i));
            step("burst", '1, d);
            check("burst_fill", 32'(fill), 32'd5);
            for (int k = 0; k < N; k++) begin
                step("burst_drain", '0, '0);
                check("burst_idx", 32'(out_idx), 32'(k));
            end
        end

        // Same-slot capture on the drain edge: old word out, new word retained.
        do_reset("rst2");
        step("same_load", 5'b00001, lane(0, 16'h1111));
        step("same_drain", 5'b00001, lane(0, 16'h2222));
        check("same_old_data", 32'(out_data), 32'h1111);
        check("same_fill", 32'(fill), 32'd1);
        check("same_no_ovf", 32'(overflow), 32'd0);
        for (int k = 0; k < N + 1; k++) step("same_wait", (k == N - 1) ? 5'b11110 : 5'b0, '0);

        // Overflow: slot 2 returned twice while the head slot 0 is empty.
        do_reset("rst3");
        step("ovf_a", 5'b00100, lane(2, 16'h0033));
        step("ovf_b", 5'b00100, lane(2, 16'h0044));
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_fill", 32'(fill), 32'd1);
        step("ovf_s0", 5'b00001, lane(0, 16'h0050));
        step("ovf_s1", 5'b00010, lane(1, 16'h0051));
        step("ovf_d1", '0, '0);
        step("ovf_d2", '0, '0);
        check("ovf_idx2", 32'(out_idx), 32'd2);
        check("ovf_data2", 32'(out_data), 32'h0044);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Asynchronous reset mid-cycle with data buffered.
        step("async_load", 5'b11010, lane(1, 16'h0777) | lane(3, 16'h0888));
        step("async_drain", 5'b00001, lane(0, 16'h0999));
        #2;
        rst = 1'b0;
        #1;
        check_zero("async");
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        step("post_rst", 5'b00010, lane(1, 16'h0123));
        step("post_rst_s0", 5'b00001, lane(0, 16'h0321));
        step("post_rst_first", '0, '0);
        check("post_rst_idx0", 32'(out_idx), 32'd0);
        step("post_rst_flush", '0, '0);

        // Randomized returns against the model, with and without overflow.
        for (int k = 0; k < 300; k++) begin
            logic [N-1:0] v = '0;
            d = '0;
            for (int i = 0; i < N; i++) begin
                v[i] = ($urandom_range(0, 99) < 30);
                d |= lane(i, 16'($urandom));
            end
            step("rand", v, d);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/reorder_collector.md
# reorder_collector

Collects results returned out of order by `n_inputs` parallel variable-latency processing units and emits them strictly in issue order. Issue order is unit 0, 1, …, `n_inputs`-1, then back to 0. The block sits at the output side of the parallel processing array; its input ports connect to each unit's `vld_out`/`data_out` pair. It provides one reordered valid/data stream with no backpressure, plus occupancy and error status.

## Interface
- `width`, 16, data word width per unit.
- `n_inputs`, 5, number of parallel units and reorder slots; any value ≥ 2, not required to be a power of 2.
- `idx_width`, derived as `$clog2(n_inputs)`; not to be overridden.
- `cnt_width`, derived as `$clog2(n_inputs+1)`; not to be overridden.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `up_vld`  in  `n_inputs`  bit i is a one-cycle result pulse from unit i.
- `up_data`  in  `n_inputs*width`  result of unit i at bits `[i*width +: width]`, sampled when `up_vld[i]`=1.
- `out_vld`  out  1  one-cycle pulse; a reordered word is present.
- `out_data`  out  `width`  reordered word, valid when `out_vld`=1.
- `out_idx`  out  `idx_width`  slot/unit index of the emitted word.
- `fill`  out  `cnt_width`  number of slots currently holding unread data.
- `overflow`  out  1  sticky error: a unit returned into a slot still holding unread data.

## Operation
- State:
  - `n_inputs` slots, each holding a valid flag and a `width` data register.
  - Read pointer `rd_ptr` (`idx_width` bits).
  - `fill` counter and `overflow` flag.
- Capture: on each edge, for every i with `up_vld[i]`=1, slot i gets valid=1 and data=`up_data[i]`. Any number of bits may be set in the same cycle.
- Drain: on each edge, if slot[`rd_ptr`] is valid (its registered flag, sampled before this edge's capture):
  - `out_vld`←1, `out_data`←slot data, `out_idx`←`rd_ptr`;
  - slot valid is cleared;
  - `rd_ptr` advances: `rd_ptr`==`n_inputs`-1 wraps to 0, otherwise +1.
- No drain on an edge: `out_vld`←0. `out_data` and `out_idx` hold their previous values.
- Same-slot capture and drain on one edge: the old data is emitted. The new data is stored and the slot stays valid.
- Overflow: `up_vld[i]`=1 while slot i is valid and not being drained this edge.
  - `overflow`←1 and stays 1 until reset.
  - The new data overwrites the slot; valid stays 1 and `fill` is unchanged for that slot.
- `fill` update each edge: `fill` + (number of captures into empty or draining slots) − (1 if drain).
  - `fill` never exceeds `n_inputs` and never underflows.
- Upstream contract (not checked beyond overflow): unit i returns at most one result per issue of index i.
- Downstream contract: always accepts; there is no ready input.

## Timing
- Reset values (asserted asynchronously, released synchronously to `clk` by the system):
  - all slot valid flags 0, slot data 0;
  - `rd_ptr`=0, `out_vld`=0, `out_data`=0, `out_idx`=0, `fill`=0, `overflow`=0.
- Latency: a result captured at edge t whose slot equals `rd_ptr` appears on `out_vld` after edge t+1. Minimum latency is 1 cycle; there is no combinational bypass.
- Throughput: at most one output per cycle. A full buffer drains in `n_inputs` consecutive cycles.
- Head-of-line blocking: later slots wait, holding their data, until slot `rd_ptr` arrives. `out_vld` stays 0 meanwhile.
- Reset mid-operation: all buffered data is discarded. After reset releases, the first output is slot 0.
- All outputs are registered.

## Test plan
- Reset, then nothing else: all outputs 0. Async check: assert `rst`=0 mid-cycle and require outputs to clear before the next edge.
- In-order returns, `n_inputs`=5, `width`=16:
  - stimulus: `up_vld[i]` with data 16'h0A00+i on consecutive cycles i=0..4;
  - required: `out_data` 0A00..0A04 with `out_idx` 0..4 on 5 consecutive `out_vld` pulses, each 1 cycle after its capture.
- Reverse returns: units 4,3,2,1,0 return on cycles 0..4.
  - `out_vld` stays 0 until slot 0 is captured;
  - then 5 back-to-back outputs with `out_idx` 0,1,2,3,4;
  - `fill` peaks at 5; no `overflow`.
- All 5 `up_vld` bits set in one cycle: `fill`=5, then 5 consecutive outputs in order. A second round in the same pattern then starts again at `out_idx`=0, verifying wrap from 4 to 0.
- Same-slot capture while draining: slot 0 holds 16'h1111 at `rd_ptr`=0, and `up_vld[0]` with 16'h2222 arrives on the drain edge.
  - required: emits 1111; slot 0 stays valid with 2222; `overflow`=0.
- Overflow: `up_vld[2]` twice (data 0x0033, then 0x0044) while `rd_ptr`=0 and slot 0 is empty.
  - required: `overflow`=1 and sticky; `fill`=1.
  - After slots 0 and 1 arrive, `out_idx`=2 emits 0x0044.
